// File: rtl/handshake_pkg.sv
// handshake_pkg: definitions shared by the sender and receiver ends of the
// four-phase Req/Ack word link (default widths and receiver state encodings).
package handshake_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        ACK_HIGH = 2'd2,
        DONE     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/req_synchronizer.sv
// req_synchronizer: two-flop synchronizer with synchronous active-high reset
// to 0, used to bring the sender's Req into the receiver clock domain.
// Optional feature macro: REQ_SYNC_EN. The module is only compiled when the
// synchronizer is enabled, so the default build has no unused top-level module.
`ifdef REQ_SYNC_EN
module req_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic sync1_d;
    logic sync1_q;
    logic sync2_d;
    logic sync2_q;

    // Next values of the two synchronizer stages.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
    end

    // Synchronizer flops, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync_out = sync2_q;

endmodule
`endif

// File: rtl/receiver.sv
// receiver: receiving end of the four-phase Req/Ack word link. Captures one
// word per handshake, writes it to a 2**ADDR_WIDTH-entry memory at an
// auto-incrementing address and pulses Ready after the last word of a block.
// Optional feature macro: REQ_SYNC_EN (two-flop synchronizer on Req).
module receiver
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Receive,
    input  logic                  Req,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic                  Ack,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Ready,
    output logic                  Busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = {ADDR_WIDTH{1'b1}};

    logic req_eff_s;

`ifdef REQ_SYNC_EN
    req_synchronizer u_req_sync (
        .clk      (Clock),
        .reset    (Reset),
        .async_in (Req),
        .sync_out (req_eff_s)
    );
`else
    assign req_eff_s = Req;
`endif

    rx_state_e             state_d;
    rx_state_e             state_q;
    logic [ADDR_WIDTH-1:0] counter_d;
    logic [ADDR_WIDTH-1:0] counter_q;
    logic                  ack_d;
    logic                  ack_q;
    logic                  we_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ready_d;
    logic                  ready_q;
    logic                  busy_d;
    logic                  busy_q;

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        ack_d     = ack_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        dout_d    = dout_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                ack_d  = 1'b0;
                busy_d = 1'b0;
                if (Receive) begin
                    state_d   = WAIT_REQ;
                    busy_d    = 1'b1;
                    counter_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_REQ: begin
                // Req already high here is always a fresh word, because
                // ACK_HIGH is only left once Req has dropped.
                if (req_eff_s) begin
                    dout_d  = DataIn;
                    addr_d  = counter_q;
                    we_d    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK_HIGH;
                end else begin
                    state_d = WAIT_REQ;
                end
            end
            ACK_HIGH: begin
                if (req_eff_s) begin
                    ack_d   = 1'b1;
                    state_d = ACK_HIGH;
                end else begin
                    ack_d     = 1'b0;
                    counter_d = counter_q + ADDR_WIDTH'(1);
                    if (counter_q == LAST_WORD) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_REQ;
                    end
                end
            end
            DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                ack_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            counter_q <= {ADDR_WIDTH{1'b0}};
            ack_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            dout_q    <= {DATA_WIDTH{1'b0}};
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            ack_q     <= ack_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign Ack         = ack_q;
    assign WriteEnable = we_q;
    assign Address     = addr_q;
    assign DataOut     = dout_q;
    assign Ready       = ready_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed self-checking bench for the receiver. A small sender
// model drives four-phase handshakes; a negedge monitor logs every memory
// write and Ready pulse for later comparison against hand-computed values.
module tb_receiver;
    import handshake_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int AW = DEFAULT_ADDR_WIDTH;
`ifdef REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Receive;
    logic          Req;
    logic [DW-1:0] DataIn;
    logic          Ack;
    logic          WriteEnable;
    logic [AW-1:0] Address;
    logic [DW-1:0] DataOut;
    logic          Ready;
    logic          Busy;

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            ready_wr_q[$];

    receiver dut (
        .Clock       (clk),
        .Reset       (Reset),
        .Receive     (Receive),
        .Req         (Req),
        .DataIn      (DataIn),
        .Ack         (Ack),
        .WriteEnable (WriteEnable),
        .Address     (Address),
        .DataOut     (DataOut),
        .Ready       (Ready),
        .Busy        (Busy)
    );

    always #5 clk = ~clk;

    // Log memory writes and Ready pulses (with the write count at that moment).
    always @(negedge clk) begin
        if (WriteEnable) begin
            wr_addr_q.push_back(Address);
            wr_data_q.push_back(DataOut);
        end
        if (Ready) begin
            ready_wr_q.push_back(wr_addr_q.size());
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        Receive = 1'b0;
        Req     = 1'b0;
        tick();
        tick();
        Reset   = 1'b0;
    endtask

    task automatic wait_ack(input logic target, input string tag, output int lat);
        lat = 0;
        while (Ack !== target && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        if (Ack !== target) begin
            check_val({tag, "_timeout"}, 32'(Ack), 32'(target));
        end
    endtask

    // One full four-phase handshake; Req stays high for 'hold' extra cycles.
    task automatic send_word(input logic [DW-1:0] data, input logic [AW-1:0] exp_addr,
                             input int hold, input bit chk_lat);
        int lat;
        Req    = 1'b1;
        DataIn = data;
        wait_ack(1'b1, "ack_rise", lat);
        if (chk_lat) check_val("ack_rise_lat", 32'(lat), 32'(LAT));
        check_val("we_on_ack", 32'(WriteEnable), 32'd1);
        check_val("addr", 32'(Address), 32'(exp_addr));
        check_val("data", 32'(DataOut), 32'(data));
        check_val("busy", 32'(Busy), 32'd1);
        for (int k = 0; k < hold; k++) begin
            tick();
            check_val("ack_held", 32'(Ack), 32'd1);
            check_val("we_single", 32'(WriteEnable), 32'd0);
        end
        Req = 1'b0;
        wait_ack(1'b0, "ack_fall", lat);
        if (chk_lat) check_val("ack_fall_lat", 32'(lat), 32'(LAT));
        check_val("we_after", 32'(WriteEnable), 32'd0);
    endtask

    initial begin
        int base;
        int rbase;
        int lat;

        Reset   = 1'b1;
        Receive = 1'b0;
        Req     = 1'b0;
        DataIn  = '0;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        check_val("rst_ack", 32'(Ack), 32'd0);
        check_val("rst_we", 32'(WriteEnable), 32'd0);
        check_val("rst_ready", 32'(Ready), 32'd0);
        check_val("rst_busy", 32'(Busy), 32'd0);
        check_val("rst_addr", 32'(Address), 32'd0);
        check_val("rst_dout", 32'(DataOut), 32'd0);

        // Full block of 16 words; word 3 holds Req high for 10 cycles
        base  = wr_addr_q.size();
        Receive = 1'b1;
        tick();
        Receive = 1'b0;
        check_val("busy_armed", 32'(Busy), 32'd1);
        check_val("ack_armed", 32'(Ack), 32'd0);
        for (int i = 0; i < 16; i++) begin
            send_word(16'(16'hA000 + i), 4'(i), (i == 3) ? 9 : 0, 1'b1);
        end
        tick();
        check_val("ready_pulse", 32'(Ready), 32'd1);
        check_val("busy_done", 32'(Busy), 32'd0);
        tick();
        check_val("ready_once", 32'(Ready), 32'd0);
        check_val("blk_wr_cnt", 32'(wr_addr_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_val("blk_log_addr", 32'(wr_addr_q[base + i]), 32'(i));
            check_val("blk_log_data", 32'(wr_data_q[base + i]), 32'(16'hA000 + i));
        end

        // Reset during ACK_HIGH of word 7 with Req still high
        Receive = 1'b1;
        tick();
        Receive = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_word(16'(16'hB000 + i), 4'(i), 0, 1'b1);
        end
        Req    = 1'b1;
        DataIn = 16'hB007;
        wait_ack(1'b1, "ack_rise7", lat);
        check_val("addr7", 32'(Address), 32'd7);
        Reset = 1'b1;
        tick();
        check_val("mid_rst_ack", 32'(Ack), 32'd0);
        check_val("mid_rst_busy", 32'(Busy), 32'd0);
        check_val("mid_rst_addr", 32'(Address), 32'd0);
        check_val("mid_rst_dout", 32'(DataOut), 32'd0);
        Reset = 1'b0;
        Req   = 1'b0;
        tick();
        Receive = 1'b1;
        tick();
        Receive = 1'b0;
        send_word(16'hB100, 4'd0, 0, 1'b1);
        do_reset();

        // Req high while idle: ignored until Receive, then captured at address 0
        base   = wr_addr_q.size();
        Req    = 1'b1;
        DataIn = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("idle_no_ack", 32'(Ack), 32'd0);
        end
        check_val("idle_no_we", 32'(wr_addr_q.size() - base), 32'd0);
        Receive = 1'b1;
        tick();
        Receive = 1'b0;
        wait_ack(1'b1, "idle_cap", lat);
        check_val("idle_cap_addr", 32'(Address), 32'd0);
        check_val("idle_cap_data", 32'(DataOut), 32'h0000BEEF);
        check_val("idle_cap_we", 32'(WriteEnable), 32'd1);
        Req = 1'b0;
        wait_ack(1'b0, "idle_fall", lat);
        do_reset();

        // Back-to-back blocks with Receive held high
        base    = wr_addr_q.size();
        rbase   = ready_wr_q.size();
        Receive = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send_word(16'(16'hC000 + i), 4'(i), 0, (i % 16) != 0);
        end
        Receive = 1'b0;
        repeat (4) tick();
        check_val("b2b_ready_cnt", 32'(ready_wr_q.size() - rbase), 32'd2);
        if (ready_wr_q.size() - rbase >= 2) begin
            check_val("b2b_ready0_at", 32'(ready_wr_q[rbase] - base), 32'd16);
            check_val("b2b_ready1_at", 32'(ready_wr_q[rbase + 1] - base), 32'd32);
        end
        check_val("b2b_wr_cnt", 32'(wr_addr_q.size() - base), 32'd32);
        for (int i = 0; i < 32; i++) begin
            check_val("b2b_log_addr", 32'(wr_addr_q[base + i]), 32'(i % 16));
            check_val("b2b_log_data", 32'(wr_data_q[base + i]), 32'(16'hC000 + i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
